// File: rtl/esteira_planta_if.sv
// esteira_planta_if -- controller <-> bottling plant signal bundle.
// Ports (signals):
//   M   conveyor motor command  (controller -> plant)
//   EV  fill-valve command      (controller -> plant)
//   VE  seal/cork command       (controller -> plant)
//   PG  bottle-present sensor   (plant -> controller)
//   CH  bottle-full sensor      (plant -> controller)
//   RO  cork-inserted sensor    (plant -> controller)
// Modports: master = controller side, slave = plant model side.
interface esteira_planta_if;
    logic M;
    logic EV;
    logic VE;
    logic PG;
    logic CH;
    logic RO;

    modport master (output M, output EV, output VE, input PG, input CH, input RO);
    modport slave  (input M, input EV, input VE, output PG, output CH, output RO);
endinterface

// File: rtl/esteira_planta.sv
// esteira_planta -- behavioural model of a bottling conveyor (transport,
// fill, cork, exit) answering a controller with sensor feedback, counting
// finished bottles and flagging protocol violations.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   bus            esteira_planta_if.slave: M/EV/VE in, PG/CH/RO out
//   cont_garrafas  completed bottles, 0..99 wrapping
//   duzia          one-cycle pulse each 12 completed bottles
//   erro           sticky protocol-violation flag
//   estado         current FSM state code (debug)
module esteira_planta #(
    parameter int T_TRANSP = 8,
    parameter int T_ENCHE  = 6,
    parameter int T_VEDA   = 3,
    parameter int T_SAIDA  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    esteira_planta_if.slave       bus,
    output logic [6:0]            cont_garrafas,
    output logic                  duzia,
    output logic                  erro,
    output logic [2:0]            estado
);

    localparam int TMAX_A = (T_TRANSP > T_ENCHE) ? T_TRANSP : T_ENCHE;
    localparam int TMAX_B = (T_VEDA > T_SAIDA) ? T_VEDA : T_SAIDA;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] LIM_TRANSP = TW'(T_TRANSP - 1);
    localparam logic [TW-1:0] LIM_ENCHE  = TW'(T_ENCHE - 1);
    localparam logic [TW-1:0] LIM_VEDA   = TW'(T_VEDA - 1);
    localparam logic [TW-1:0] LIM_SAIDA  = TW'(T_SAIDA - 1);
    localparam logic [TW-1:0] ONE        = TW'(1);

    typedef enum logic [2:0] {
        ESTEIRA  = 3'd0,
        POSIC    = 3'd1,
        ENCHENDO = 3'd2,
        CHEIA    = 3'd3,
        VEDANDO  = 3'd4,
        VEDADA   = 3'd5,
        SAINDO   = 3'd6,
        ILEGAL   = 3'd7
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   next_timer;
    logic [3:0]      dozen;
    logic            viol;
    logic            done;
    logic            next_pg;
    logic            next_ch;
    logic            next_ro;

    // Next-state, timer and violation decode. The timer only advances on the
    // phase's driving input; entering a timed phase from a waiting state
    // loads 1 because the entry edge itself already counts as a cycle.
    always_comb begin
        next_state = state;
        next_timer = timer;
        viol       = 1'b0;
        done       = 1'b0;
        case (state)
            ESTEIRA: begin
                viol = bus.EV | bus.VE;
                if (bus.M) begin
                    if (timer == LIM_TRANSP) begin
                        next_state = POSIC;
                        next_timer = '0;
                    end else begin
                        next_timer = timer + ONE;
                    end
                end else begin
                    next_timer = timer;
                end
            end
            POSIC: begin
                // M together with EV here is legal: the bottle just starts filling
                viol = bus.VE;
                if (bus.EV) begin
                    next_state = ENCHENDO;
                    next_timer = ONE;
                end else begin
                    next_timer = timer;
                end
            end
            ENCHENDO: begin
                // M here is flagged but does not disturb the fill progress
                viol = bus.VE | bus.M;
                if (bus.EV) begin
                    if (timer == LIM_ENCHE) begin
                        next_state = CHEIA;
                        next_timer = '0;
                    end else begin
                        next_timer = timer + ONE;
                    end
                end else begin
                    next_timer = timer;
                end
            end
            CHEIA: begin
                viol = bus.EV;
                if (bus.VE) begin
                    next_state = VEDANDO;
                    next_timer = ONE;
                end else begin
                    next_timer = timer;
                end
            end
            VEDANDO: begin
                viol = bus.EV | bus.M;
                if (bus.VE) begin
                    if (timer == LIM_VEDA) begin
                        next_state = VEDADA;
                        next_timer = '0;
                    end else begin
                        next_timer = timer + ONE;
                    end
                end else begin
                    next_timer = timer;
                end
            end
            VEDADA: begin
                viol = bus.EV | bus.VE;
                if (bus.M) begin
                    next_state = SAINDO;
                    next_timer = ONE;
                end else begin
                    next_timer = timer;
                end
            end
            SAINDO: begin
                viol = bus.EV | bus.VE;
                if (bus.M) begin
                    if (timer == LIM_SAIDA) begin
                        next_state = ESTEIRA;
                        next_timer = '0;
                        done       = 1'b1;
                    end else begin
                        next_timer = timer + ONE;
                    end
                end else begin
                    next_timer = timer;
                end
            end
            default: begin
                // unused code 7: recover to the idle conveyor state
                next_state = ESTEIRA;
                next_timer = '0;
            end
        endcase
    end

    // Sensor values for the state being entered, so the registered outputs
    // line up with the new state in the cycle after the edge.
    always_comb begin
        next_pg = 1'b0;
        next_ch = 1'b0;
        next_ro = 1'b0;
        case (next_state)
            POSIC, ENCHENDO: begin
                next_pg = 1'b1;
            end
            CHEIA, VEDANDO: begin
                next_pg = 1'b1;
                next_ch = 1'b1;
            end
            VEDADA, SAINDO: begin
                next_pg = 1'b1;
                next_ch = 1'b1;
                next_ro = 1'b1;
            end
            default: begin
                next_pg = 1'b0;
            end
        endcase
    end

    // State, timer, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ESTEIRA;
            timer         <= '0;
            dozen         <= 4'd0;
            cont_garrafas <= 7'd0;
            duzia         <= 1'b0;
            erro          <= 1'b0;
            estado        <= 3'd0;
            bus.PG        <= 1'b0;
            bus.CH        <= 1'b0;
            bus.RO        <= 1'b0;
        end else begin
            state  <= next_state;
            timer  <= next_timer;
            erro   <= erro | viol;
            estado <= next_state;
            bus.PG <= next_pg;
            bus.CH <= next_ch;
            bus.RO <= next_ro;
            if (done) begin
                cont_garrafas <= (cont_garrafas == 7'd99) ? 7'd0 : cont_garrafas + 7'd1;
                dozen         <= (dozen == 4'd11) ? 4'd0 : dozen + 4'd1;
                duzia         <= (dozen == 4'd11);
            end else begin
                duzia <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_esteira_planta.sv
// tb_esteira_planta -- directed self-checking bench for esteira_planta.
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// that same point, so each step() shows the effect of exactly one edge.
module tb_esteira_planta;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] cont_garrafas;
    logic       duzia;
    logic       erro;
    logic [2:0] estado;
    int         n_pass  = 0;
    int         n_total = 0;

    esteira_planta_if bus ();

    esteira_planta dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .cont_garrafas (cont_garrafas),
        .duzia         (duzia),
        .erro          (erro),
        .estado        (estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic m, input logic ev, input logic ve);
        bus.M  = m;
        bus.EV = ev;
        bus.VE = ve;
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input logic m, input logic ev, input logic ve, input int n);
        for (int i = 0; i < n; i++) step(m, ev, ve);
    endtask

    task automatic do_reset();
        bus.M  = 1'b0;
        bus.EV = 1'b0;
        bus.VE = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // one nominal bottle, ending on the exit edge (no trailing idle)
    task automatic bottle_body();
        step_n(1'b1, 1'b0, 1'b0, 8);
        step(1'b0, 1'b0, 1'b0);
        step_n(1'b0, 1'b1, 1'b0, 6);
        step(1'b0, 1'b0, 1'b0);
        step_n(1'b0, 1'b0, 1'b1, 3);
        step(1'b0, 1'b0, 1'b0);
        step_n(1'b1, 1'b0, 1'b0, 4);
    endtask

    task automatic bottle();
        bottle_body();
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset held with M high: nothing may move
        reset  = 1'b1;
        bus.M  = 1'b1;
        bus.EV = 1'b0;
        bus.VE = 1'b0;
        #32;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_sensors", 32'({bus.PG, bus.CH, bus.RO}), 32'd0);
        chk("rst_cont", 32'(cont_garrafas), 32'd0);
        chk("rst_flags", 32'({duzia, erro}), 32'd0);
        bus.M = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // transport: PG after the 8th M edge
        step_n(1'b1, 1'b0, 1'b0, 7);
        chk("transp_7_pg", 32'(bus.PG), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("transp_8_pg", 32'(bus.PG), 32'd1);
        chk("transp_8_estado", 32'(estado), 32'd1);

        // transport with a 3-cycle motor pause: timer holds
        do_reset();
        step_n(1'b1, 1'b0, 1'b0, 4);
        step_n(1'b0, 1'b0, 1'b0, 3);
        chk("pause_pg", 32'(bus.PG), 32'd0);
        step_n(1'b1, 1'b0, 1'b0, 3);
        chk("pause_7_pg", 32'(bus.PG), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("pause_8_pg", 32'(bus.PG), 32'd1);

        // rest of a nominal cycle
        step(1'b0, 1'b0, 1'b0);
        step_n(1'b0, 1'b1, 1'b0, 5);
        chk("fill_5_ch", 32'(bus.CH), 32'd0);
        chk("fill_5_estado", 32'(estado), 32'd2);
        step(1'b0, 1'b1, 1'b0);
        chk("fill_6_ch", 32'(bus.CH), 32'd1);
        chk("fill_6_estado", 32'(estado), 32'd3);
        step(1'b0, 1'b0, 1'b0);
        step_n(1'b0, 1'b0, 1'b1, 2);
        chk("seal_2_ro", 32'(bus.RO), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("seal_3_ro", 32'(bus.RO), 32'd1);
        chk("seal_3_estado", 32'(estado), 32'd5);
        step(1'b0, 1'b0, 1'b0);
        step_n(1'b1, 1'b0, 1'b0, 3);
        chk("exit_3_sensors", 32'({bus.PG, bus.CH, bus.RO}), 32'd7);
        chk("exit_3_cont", 32'(cont_garrafas), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("exit_4_sensors", 32'({bus.PG, bus.CH, bus.RO}), 32'd0);
        chk("exit_4_cont", 32'(cont_garrafas), 32'd1);
        chk("exit_4_erro", 32'(erro), 32'd0);
        chk("exit_4_estado", 32'(estado), 32'd0);

        // M together with EV in POSIC: legal start of filling
        do_reset();
        step_n(1'b1, 1'b0, 1'b0, 8);
        step(1'b1, 1'b1, 1'b0);
        chk("posic_m_ev_estado", 32'(estado), 32'd2);
        chk("posic_m_ev_erro", 32'(erro), 32'd0);

        // M during filling: error, state kept, fill still completes on 6th EV
        do_reset();
        step_n(1'b1, 1'b0, 1'b0, 8);
        step(1'b0, 1'b0, 1'b0);
        step_n(1'b0, 1'b1, 1'b0, 2);
        step(1'b1, 1'b1, 1'b0);
        chk("fill_m_erro", 32'(erro), 32'd1);
        chk("fill_m_estado", 32'(estado), 32'd2);
        step_n(1'b0, 1'b1, 1'b0, 2);
        chk("fill_m_5_ch", 32'(bus.CH), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("fill_m_6_ch", 32'(bus.CH), 32'd1);

        // EV spill in ESTEIRA: sticky until reset
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        chk("spill_erro", 32'(erro), 32'd1);
        chk("spill_estado", 32'(estado), 32'd0);
        bottle();
        chk("spill_sticky_erro", 32'(erro), 32'd1);
        chk("spill_sticky_cont", 32'(cont_garrafas), 32'd1);
        do_reset();
        chk("spill_cleared", 32'(erro), 32'd0);

        // asynchronous reset in VEDANDO with 5 bottles done
        for (int b = 0; b < 5; b++) bottle();
        step_n(1'b1, 1'b0, 1'b0, 8);
        step(1'b0, 1'b0, 1'b0);
        step_n(1'b0, 1'b1, 1'b0, 6);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("pre_arst_estado", 32'(estado), 32'd4);
        chk("pre_arst_cont", 32'(cont_garrafas), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_sensors", 32'({bus.PG, bus.CH, bus.RO}), 32'd0);
        chk("arst_cont", 32'(cont_garrafas), 32'd0);
        chk("arst_estado", 32'(estado), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // dozen pulse and 99 -> 0 wrap
        for (int b = 0; b < 11; b++) bottle();
        chk("cont_11", 32'(cont_garrafas), 32'd11);
        chk("duzia_11", 32'(duzia), 32'd0);
        bottle_body();
        chk("cont_12", 32'(cont_garrafas), 32'd12);
        chk("duzia_12", 32'(duzia), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("duzia_12_after", 32'(duzia), 32'd0);
        for (int b = 0; b < 87; b++) bottle();
        chk("cont_99", 32'(cont_garrafas), 32'd99);
        bottle();
        chk("cont_wrap", 32'(cont_garrafas), 32'd0);
        chk("wrap_erro", 32'(erro), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
